// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl
//   Instruction-side memory controller for the IF stage. On a fetch request it
//   reads four bytes from the byte-wide unified RAM port (data side has
//   priority, so each read waits for mem_grant_i) and assembles a
//   little-endian 32-bit instruction. done_o pulses for one cycle when
//   inst_o/pc_o are updated; the IF stage stalls while done_o is low.
//
//   Optional feature: define ICACHE_EN to place a direct-mapped,
//   one-word-per-line instruction cache (2**ICACHE_INDEX_W lines) in front
//   of the RAM port. Without it every fetch goes to RAM.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   pc_i         fetch address (bits [1:0] ignored)
//   req_i        fetch request, sampled only while idle
//   flush_i      abort the in-progress fetch
//   mem_grant_i  RAM port granted to the instruction side this cycle
//   mem_a_o      RAM byte address
//   mem_rd_o     RAM read strobe
//   mem_din_i    RAM read data, valid the cycle after a granted read
//   pc_o         word address of inst_o
//   inst_o       fetched instruction
//   done_o       1 = inst_o valid this cycle, 0 = busy
module inst_fetch_ctrl #(
    parameter int ICACHE_INDEX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        req_i,
    input  logic        flush_i,
    input  logic        mem_grant_i,
    output logic [31:0] mem_a_o,
    output logic        mem_rd_o,
    input  logic [7:0]  mem_din_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        done_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      r_state;
    logic [29:0] r_pc_word;
    logic [2:0]  r_issue_cnt;
    logic [2:0]  r_recv_cnt;
    logic        r_pend_v;
    logic [1:0]  r_pend_idx;
    logic [31:0] r_buf;
    logic [31:0] r_mem_a;
    logic        r_mem_rd;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_done;

    logic        w_issue;
    logic [2:0]  w_issue_nxt;
    logic        w_last;
    logic        w_hit;
    logic [31:0] w_hit_data;
    logic [31:0] w_word;
    logic [1:0]  w_unused_pc_lo;

    assign w_unused_pc_lo = pc_i[1:0];

    // r_mem_rd is high exactly while issue_cnt < 4 in FETCH
    assign w_issue     = (r_state == S_FETCH) && r_mem_rd && mem_grant_i;
    assign w_issue_nxt = r_issue_cnt + 3'd1;
    // reads return in order, so the fourth received byte is byte 3
    assign w_last      = (r_state == S_FETCH) && r_pend_v && (r_recv_cnt == 3'd3);

    // buffer with the byte arriving this cycle merged in
    always_comb begin
        w_word = r_buf;
        case (r_pend_idx)
            2'd0:    w_word[7:0]   = mem_din_i;
            2'd1:    w_word[15:8]  = mem_din_i;
            2'd2:    w_word[23:16] = mem_din_i;
            default: w_word[31:24] = mem_din_i;
        endcase
    end

`ifdef ICACHE_EN
    localparam int LINES = 1 << ICACHE_INDEX_W;
    localparam int TAG_W = 30 - ICACHE_INDEX_W;

    logic [TAG_W-1:0]          r_tag  [LINES];
    logic [31:0]               r_data [LINES];
    logic [LINES-1:0]          r_valid;
    logic [ICACHE_INDEX_W-1:0] w_req_idx;
    logic [ICACHE_INDEX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0]          w_req_tag;
    logic [TAG_W-1:0]          w_fill_tag;
    logic                      w_fill;

    assign w_req_idx  = pc_i[ICACHE_INDEX_W+1:2];
    assign w_req_tag  = pc_i[31:ICACHE_INDEX_W+2];
    assign w_fill_idx = r_pc_word[ICACHE_INDEX_W-1:0];
    assign w_fill_tag = r_pc_word[29:ICACHE_INDEX_W];
    assign w_hit      = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_hit_data = r_data[w_req_idx];
    // a flush in the completion cycle cancels the fill along with done_o
    assign w_fill     = w_last && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= w_word;
        end
    end
`else
    logic [31:0] w_unused_cfg;

    assign w_unused_cfg = ICACHE_INDEX_W;
    assign w_hit        = 1'b0;
    assign w_hit_data   = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc_word   <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_pend_v    <= 1'b0;
            r_pend_idx  <= '0;
            r_buf       <= '0;
            r_mem_a     <= '0;
            r_mem_rd    <= 1'b0;
            r_pc        <= '0;
            r_inst      <= NOP;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_i && !flush_i) begin
                        if (w_hit) begin
                            r_inst <= w_hit_data;
                            r_pc   <= {pc_i[31:2], 2'b00};
                            r_done <= 1'b1;
                        end else begin
                            r_pc_word   <= pc_i[31:2];
                            r_issue_cnt <= '0;
                            r_recv_cnt  <= '0;
                            r_pend_v    <= 1'b0;
                            r_mem_rd    <= 1'b1;
                            r_mem_a     <= {pc_i[31:2], 2'b00};
                            r_state     <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (flush_i) begin
                        r_pend_v <= 1'b0;
                        r_mem_rd <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        // issue side: address advances only on a granted read
                        r_pend_v <= w_issue;
                        if (w_issue) begin
                            r_issue_cnt <= w_issue_nxt;
                            r_pend_idx  <= r_issue_cnt[1:0];
                            if (w_issue_nxt[2]) begin
                                r_mem_rd <= 1'b0;
                            end else begin
                                r_mem_a <= {r_pc_word, w_issue_nxt[1:0]};
                            end
                        end
                        // receive side: independent of this cycle's grant
                        if (r_pend_v) begin
                            r_buf      <= w_word;
                            r_recv_cnt <= r_recv_cnt + 3'd1;
                        end
                        if (w_last) begin
                            r_inst  <= w_word;
                            r_pc    <= {r_pc_word, 2'b00};
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_a_o  = r_mem_a;
    assign mem_rd_o = r_mem_rd;
    assign pc_o     = r_pc;
    assign inst_o   = r_inst;
    assign done_o   = r_done;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl. Inputs are driven on the falling
// edge; a RAM responder answers granted reads one cycle later. Expected
// completions go into a scoreboard queue and a monitor sampling just after
// each rising edge pops and compares them whenever done_o is high.
module tb_inst_fetch_ctrl;

    localparam int IW = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = '0;
    logic        req_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        mem_grant_i = 1'b0;
    logic [31:0] mem_a_o;
    logic        mem_rd_o;
    logic [7:0]  mem_din_i = '0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        done_o;

    inst_fetch_ctrl #(.ICACHE_INDEX_W(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .req_i       (req_i),
        .flush_i     (flush_i),
        .mem_grant_i (mem_grant_i),
        .mem_a_o     (mem_a_o),
        .mem_rd_o    (mem_rd_o),
        .mem_din_i   (mem_din_i),
        .pc_o        (pc_o),
        .inst_o      (inst_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state
    bit          model_active = 1'b0;
    logic [31:0] model_pc;
    int          model_T;
    int          model_grants;
    int          model_due;
    int          grant_pct = 100;
    bit [15:0]   nogrant_mask = '0;
    bit          pend_v = 1'b0;
    logic [31:0] pend_a;
    logic [31:0] cmodel [int];

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'h0000_1000: return 8'h93;
            32'h0000_1001: return 8'h00;
            32'h0000_1002: return 8'h10;
            32'h0000_1003: return 8'h00;
            default: ;
        endcase
        h = a * 32'h9E37_79B1;
        return h[23:16] ^ a[7:0];
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] pw);
        return {ram_byte(pw + 3), ram_byte(pw + 2), ram_byte(pw + 1), ram_byte(pw)};
    endfunction

    function automatic int cidx(input logic [31:0] pw);
        return int'((pw >> 2) % (32'd1 << IW));
    endfunction

    function automatic bit cache_hit(input logic [31:0] pw);
`ifdef ICACHE_EN
        int i;
        i = cidx(pw);
        if (cmodel.exists(i)) return (cmodel[i] == pw);
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one cycle: choose grant, answer last cycle's read, check the issue side
    task automatic tick();
        int   off;
        exp_t t;
        @(negedge clk);
        off = cyc - model_T;
        if (model_active && off >= 0 && off < 16 && nogrant_mask[off])
            mem_grant_i = 1'b0;
        else
            mem_grant_i = ($urandom_range(1, 100) <= grant_pct);
        mem_din_i = pend_v ? ram_byte(pend_a) : 8'($urandom);
        pend_v    = mem_rd_o && mem_grant_i;
        pend_a    = mem_a_o;
        if (model_active && cyc > model_T) begin
            check("rd_strobe", {31'b0, mem_rd_o}, 32'd1);
            check("rd_addr", mem_a_o, {model_pc[31:2], 2'(model_grants)});
            if (mem_grant_i) begin
                model_grants++;
                if (model_grants == 4) begin
                    model_active = 1'b0;
                    model_due    = cyc + 2;
                    if (sb.size() > 0) begin
                        t = sb.pop_back();
                        t.due = model_due;
                        sb.push_back(t);
                    end
                end
            end
        end else begin
            check("rd_idle", {31'b0, mem_rd_o}, 32'd0);
        end
    endtask

    task automatic check_reset_state();
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_rd", {31'b0, mem_rd_o}, 32'd0);
        check("rst_addr", mem_a_o, 32'd0);
        check("rst_inst", inst_o, 32'h0000_0013);
        check("rst_pc", pc_o, 32'd0);
    endtask

    // issue one fetch in the current cycle and return in its done cycle
    // (or right after a flush/reset abort)
    task automatic do_fetch(input logic [31:0] pc, input int flush_at,
                            input int rst_at, input bit rnd_flush);
        logic [31:0] pw;
        exp_t        e;
        pw      = {pc[31:2], 2'b00};
        pc_i    = pc;
        req_i   = 1'b1;
        flush_i = 1'b0;
        model_T = cyc;
        e.pc    = pw;
        e.inst  = ram_word(pw);
        if (cache_hit(pw)) begin
            e.due = cyc + 1;
            sb.push_back(e);
            tick();
            req_i = 1'b0;
            return;
        end
        e.due = -1;
        sb.push_back(e);
        model_active = 1'b1;
        model_pc     = pw;
        model_grants = 0;
        model_due    = 32'h7fff_ffff;
        for (int n = 0; n < 300; n++) begin
            tick();
            req_i = 1'b0;
            if ((cyc - model_T) == rst_at) begin
                rst          = 1'b1;
                model_active = 1'b0;
                void'(sb.pop_back());
                cmodel.delete();
                tick();
                rst = 1'b0;
                check_reset_state();
                return;
            end
            if (model_active && ((cyc - model_T) == flush_at ||
                                 (rnd_flush && $urandom_range(0, 15) == 0))) begin
                flush_i      = 1'b1;
                model_active = 1'b0;
                void'(sb.pop_back());
                tick();
                flush_i = 1'b0;
                return;
            end
            if (!model_active && cyc >= model_due) begin
                cmodel[cidx(pw)] = pw;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL fetch_timeout: pc %h got no completion, expected one within 300 cycles", pw);
        model_active = 1'b0;
        sb.delete();
    endtask

    // monitor: compare every completion against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done_o === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done with pc_o %h, expected none (cycle %0d)",
                             pc_o, cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_pc", pc_o, e.pc);
                    check("done_inst", inst_o, e.inst);
                    check("done_cycle", cyc, e.due);
                end
            end else if (sb.size() > 0 && sb[0].due >= 0 && cyc > sb[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_done: got none for pc %h, expected at cycle %0d",
                         sb[0].pc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int gp;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        tick();

        // basic fetch with continuous grant
        do_fetch(32'h0000_1000, -1, -1, 1'b0);
        // same fetch, no grant in T+2 and T+3
        nogrant_mask = 16'b0000_0000_0000_1100;
        do_fetch(32'h0000_1000, -1, -1, 1'b0);
        nogrant_mask = '0;
        // flush mid-fetch, then a fresh fetch
        do_fetch(32'h0000_2000, 3, -1, 1'b0);
        do_fetch(32'h0000_3000, -1, -1, 1'b0);
        // reset mid-fetch, then a normal fetch
        do_fetch(32'h0000_4000, -1, 4, 1'b0);
        do_fetch(32'h0000_1000, -1, -1, 1'b0);
        // unaligned pc is fetched word-aligned
        do_fetch(32'h0000_1002, -1, -1, 1'b0);
        // hit / conflict sequence (only hits when the cache is built in)
        do_fetch(32'h0000_1000, -1, -1, 1'b0);
        do_fetch(32'h0000_1000, -1, -1, 1'b0);
        do_fetch(32'h0000_1100, -1, -1, 1'b0);
        do_fetch(32'h0000_1000, -1, -1, 1'b0);

        // randomized grant, flushes and addresses
        for (int i = 0; i < 60; i++) begin
            gp = $urandom_range(40, 100);
            grant_pct = gp;
            do_fetch(($urandom_range(0, 15) << 8) | ($urandom_range(0, 3) << 2) |
                     $urandom_range(0, 3), -1, -1, 1'b1);
            if ($urandom_range(0, 3) == 0) tick();
        end

        grant_pct = 100;
        repeat (10) tick();
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-side memory controller that serves the IF stage. Given a fetch request and PC, it reads four bytes from the byte-wide unified RAM port and assembles a little-endian 32-bit instruction. It reports completion on `done_o`; the IF stage raises its stall request while `done_o` is Busy. An optional direct-mapped instruction cache sits in front of the RAM port.

## Interface
- `ICACHE_INDEX_W`, 6: cache index width; 2^6 = 64 one-word lines. Used only with `ICACHE_EN`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_i`  in  32  fetch address; bits [1:0] ignored, word-aligned fetch only.
- `req_i`  in  1  fetch request, level; sampled only in IDLE.
- `flush_i`  in  1  abort the in-progress fetch (branch/jump taken).
- `mem_grant_i`  in  1  RAM port granted to instruction side this cycle; data side has priority.
- `mem_a_o`  out  32  RAM byte address.
- `mem_rd_o`  out  1  RAM read strobe.
- `mem_din_i`  in  8  RAM read data, valid one cycle after a granted read.
- `pc_o`  out  32  address of `inst_o`, {pc[31:2], 2'b00}.
- `inst_o`  out  32  fetched instruction.
- `done_o`  out  1  1 = Done (`inst_o` valid this cycle), 0 = Busy.

## Operation
- States: IDLE and FETCH.
- IDLE:
  - If `req_i`=1 and `flush_i`=0: latch `pc_i[31:2]`, clear `issue_cnt` and `recv_cnt`, go to FETCH.
  - If `flush_i`=1: stay in IDLE.
- FETCH, issue side:
  - While `issue_cnt` < 4: `mem_rd_o`=1 and `mem_a_o`={pc[31:2], issue_cnt[1:0]}.
  - `issue_cnt` increments only in cycles where `mem_grant_i`=1.
  - With `mem_grant_i`=0, `mem_a_o` holds and nothing is issued.
- FETCH, receive side:
  - A granted read sets `pend_v` and records `pend_idx`.
  - Next cycle, `mem_din_i` is written into buffer byte `pend_idx` (bits [8k+7:8k]) and `recv_cnt` increments.
  - This happens independently of the grant in that cycle.
- Completion:
  - When byte 3 is captured, register `inst_o`/`pc_o`, pulse `done_o` for exactly one cycle, and return to IDLE.
  - The done cycle is an IDLE cycle, so a new `req_i` may be sampled in it.
- Flush:
  - `flush_i`=1 in FETCH: return to IDLE next cycle, drop any pending byte, and do not assert `done_o` for that fetch.
  - `flush_i` has priority over completion in the same cycle.
  - A `done_o` already being driven in the flush cycle is not retracted.
- Outputs:
  - `mem_rd_o`=0 and `mem_a_o` holds its last value whenever no issue is active.
  - `inst_o`/`pc_o` hold until the next completion.
- Reset (any state, including mid-fetch):
  - Next cycle: IDLE; `done_o`=0, `mem_rd_o`=0, `mem_a_o`=0, `inst_o`=0x00000013 (NOP), `pc_o`=0.
  - Counters and `pend_v` cleared; in-flight bytes discarded.
  - With `ICACHE_EN`, all valid bits cleared.

## Timing
- Fetch latency with continuous grant:
  - `req_i` sampled in cycle T.
  - Reads issued in T+1..T+4.
  - Bytes arrive in T+2..T+5.
  - `done_o`=1 in T+6.
- Each cycle without grant during issue adds exactly one cycle of latency.
- Maximum back-to-back miss throughput: one instruction per 6 cycles.
- `done_o` is never high for two consecutive cycles on a miss path.

## Configuration
- `ICACHE_EN` defined: direct-mapped cache.
  - Index = pc[ICACHE_INDEX_W+1:2]; tag = pc[31:ICACHE_INDEX_W+2]; one valid bit per line.
  - Hit in IDLE (`req_i`=1, `flush_i`=0): `done_o`=1 in T+1 with the cached word, no RAM read, stay IDLE.
  - Miss: normal fetch; the line is written (tag, data, valid) on the completion edge.
  - Flushed fetches do not fill.
  - `flush_i` does not invalidate lines.
- `ICACHE_EN` undefined: no cache storage; every fetch takes the FETCH path.

## Test plan
- Reset, then `req_i`=1 with `pc_i`=0x00001000, RAM bytes 0x93,0x00,0x10,0x00, full grant:
  - reads at 0x1000..0x1003 in T+1..T+4;
  - T+6: `done_o`=1, `inst_o`=0x00100093, `pc_o`=0x00001000.
- Same fetch with `mem_grant_i`=0 in T+2 and T+3:
  - address 0x1001 is held for 3 cycles;
  - `done_o` in T+8 with the identical word.
- `flush_i`=1 in T+3 of a fetch at 0x2000, then a new `req_i` at 0x3000:
  - no `done_o` for 0x2000;
  - `done_o` only for 0x3000 with its correct data.
- `rst`=1 in T+4 of a fetch:
  - next cycle `done_o`=0, `mem_rd_o`=0, `inst_o`=0x00000013;
  - a subsequent fetch completes normally.
- `pc_i`=0x00001002 is fetched as 0x00001000; `pc_o`=0x00001000.
- `ICACHE_EN`:
  - fetch 0x1000 twice: first completes at T+6, second at T+1 with no `mem_rd_o`;
  - then fetch 0x1100 (same index with W=6, different tag): miss, 6-cycle fill;
  - then fetch 0x1000 again: miss.
